// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with write-back mux, write-through bypass and a
// load scoreboard that stalls issue on pending-write hazards.
module decode_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [1:0]             wr_sel,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic [DATA_W-1:0]      link_pc,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_dst,
  output logic                   stall,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic [ADDR_W:0]        pend_cnt
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_LINK = 2'b10
  } wr_sel_e;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
  logic [DATA_W-1:0] wdata;
  logic              wr_hit;
  logic              hz_rs, hz_rt, hz_dst;
  logic              issue_ok;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wdata = alu_result;
    case (wr_sel_e'(wr_sel))
      SEL_MEM:  wdata = mem_data;
      SEL_LINK: wdata = link_pc;
      default:  wdata = alu_result;
    endcase
  end

  assign wr_hit = wr_en && (wr_addr != '0);

  // Register 0 reads as zero; a same-cycle write to the read address is bypassed.
  assign rs_data = (rs_addr == '0) ? '0
                 : (wr_hit && (wr_addr == rs_addr)) ? wdata : regs_q[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0
                 : (wr_hit && (wr_addr == rt_addr)) ? wdata : regs_q[rt_addr];

  // A busy register being written back this cycle is no longer a hazard.
  assign hz_rs  = (rs_addr   != '0) && busy_q[rs_addr]   && !(wr_en && (wr_addr == rs_addr));
  assign hz_rt  = (rt_addr   != '0) && busy_q[rt_addr]   && !(wr_en && (wr_addr == rt_addr));
  assign hz_dst = (issue_dst != '0) && busy_q[issue_dst] && !(wr_en && (wr_addr == issue_dst));

  assign stall    = issue_valid && (hz_rs || hz_rt || hz_dst);
  assign issue_ok = issue_valid && !stall && (issue_dst != '0);

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    pend_cnt_d = '0;
    if (wr_hit) begin
      regs_d[wr_addr] = wdata;
      busy_d[wr_addr] = 1'b0;
    end
    // Set after clear so a new issue to the register being written back wins.
    if (issue_ok) begin
      busy_d[issue_dst] = 1'b1;
    end
    for (int i = 1; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the register array is cleared on reset because post-reset reads must return 0, which costs a reset on every storage flop.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Self-checking bench for decode_regfile_sb: directed scenarios followed by
// randomized traffic compared against a behavioural register/scoreboard model.
module tb_decode_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] rs_addr, rt_addr, wr_addr, issue_dst;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              wr_en, issue_valid, stall;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] alu_result, mem_data, link_pc;
  logic [NREG-1:0]   busy_vec;
  logic [ADDR_W:0]   pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] regs_m [NREG];
  bit   [NREG-1:0]   busy_m;

  decode_regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_sel      (wr_sel),
    .alu_result  (alu_result),
    .mem_data    (mem_data),
    .link_pc     (link_pc),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .pend_cnt    (pend_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    reset       = 1'b0;
    rs_addr     = '0;
    rt_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_sel      = 2'b00;
    alu_result  = '0;
    mem_data    = '0;
    link_pc     = '0;
    issue_valid = 1'b0;
    issue_dst   = '0;
  endtask

  function automatic logic [DATA_W-1:0] sel_m();
    if (wr_sel == 2'b01) return mem_data;
    if (wr_sel == 2'b10) return link_pc;
    return alu_result;
  endfunction

  function automatic logic [DATA_W-1:0] rd_m(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wd;
    return regs_m[a];
  endfunction

  function automatic bit hz_m(input logic [ADDR_W-1:0] a);
    return (a != 0) && busy_m[a] && !(wr_en && wr_addr == a);
  endfunction

  // Compare combinational and registered outputs with the model, then clock
  // one edge and advance the model by the same rules.
  task automatic step();
    logic [DATA_W-1:0] wd;
    bit                stall_m;
    #1;
    wd      = sel_m();
    stall_m = issue_valid && (hz_m(rs_addr) || hz_m(rt_addr) || hz_m(issue_dst));
    check("rs_data",  rs_data,  rd_m(rs_addr, wd));
    check("rt_data",  rt_data,  rd_m(rt_addr, wd));
    check("stall",    stall,    stall_m);
    check("busy_vec", busy_vec, busy_m);
    check("pend_cnt", pend_cnt, $countones(busy_m));
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_m[i] = '0;
      busy_m = '0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        regs_m[wr_addr] = wd;
        busy_m[wr_addr] = 1'b0;
      end
      if (issue_valid && !stall_m && issue_dst != 0) busy_m[issue_dst] = 1'b1;
    end
    @(negedge clock);
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return ADDR_W'($urandom_range(0, 9));
    return ADDR_W'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    logic [ADDR_W:0] pend_before;
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    busy_m = '0;
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);

    // Post-reset state and an issue with nothing pending.
    idle();
    rs_addr = 5'd3; issue_valid = 1'b1; issue_dst = 5'd0;
    #1;
    check("rst_rs_data",  rs_data,  32'h0);
    check("rst_busy_vec", busy_vec, 32'h0);
    check("rst_pend_cnt", pend_cnt, 6'd0);
    check("rst_stall",    stall,    1'b0);
    step();

    // Write-through bypass, then registered read.
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_sel = 2'b00; alu_result = 32'h1234; rs_addr = 5'd5;
    #1;
    check("bypass_rs", rs_data, 32'h1234);
    step();
    idle();
    rs_addr = 5'd5;
    #1;
    check("stored_rs", rs_data, 32'h1234);
    step();

    // Register 0 ignores writes.
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; alu_result = 32'hFFFF_FFFF; rs_addr = 5'd0;
    #1;
    check("r0_same_cycle", rs_data, 32'h0);
    step();
    idle();
    #1;
    check("r0_after", rs_data, 32'h0);
    step();

    // Load to r7, hazard, then write-back releases it.
    idle();
    issue_valid = 1'b1; issue_dst = 5'd7;
    step();
    idle();
    #1;
    check("load7_busy", busy_vec[7], 1'b1);
    check("load7_pend", pend_cnt, 6'd1);
    issue_valid = 1'b1; rt_addr = 5'd7;
    #1;
    check("load7_stall", stall, 1'b1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_sel = 2'b01; mem_data = 32'hABCD;
    #1;
    check("load7_wb_stall", stall, 1'b0);
    check("load7_wb_rt", rt_data, 32'hABCD);
    step();
    idle();
    #1;
    check("load7_cleared", busy_vec[7], 1'b0);
    step();

    // Simultaneous clear and re-issue of r9: new issue wins.
    idle();
    issue_valid = 1'b1; issue_dst = 5'd9;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; alu_result = 32'h99; issue_valid = 1'b1; issue_dst = 5'd9;
    #1;
    pend_before = pend_cnt;
    check("reissue9_stall", stall, 1'b0);
    step();
    idle();
    #1;
    check("reissue9_busy", busy_vec[9], 1'b1);
    check("reissue9_pend", pend_cnt, pend_before);
    step();

    // Three pending loads dropped by a reset that also sees a write and an issue.
    for (int d = 2; d <= 6; d += 2) begin
      idle();
      issue_valid = 1'b1; issue_dst = ADDR_W'(d);
      step();
    end
    idle();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; alu_result = 32'h3333;
    issue_valid = 1'b1; issue_dst = 5'd10;
    step();
    idle();
    #1;
    check("rst_mid_busy", busy_vec, 32'h0);
    check("rst_mid_pend", pend_cnt, 6'd0);
    check("rst_mid_r5", rs_data, 32'h0);
    for (int i = 0; i < NREG; i += 2) begin
      idle();
      rs_addr = ADDR_W'(i); rt_addr = ADDR_W'(i + 1);
      step();
    end
    idle();
    wr_en = 1'b1; wr_addr = 5'd31; wr_sel = 2'b10; link_pc = 32'h0040_0008;
    step();
    idle();
    rs_addr = 5'd31;
    #1;
    check("link31", rs_data, 32'h0040_0008);
    step();

    // Randomized traffic with addresses clustered to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      rs_addr     = rnd_addr();
      rt_addr     = rnd_addr();
      wr_en       = ($urandom_range(0, 1) == 1);
      wr_addr     = rnd_addr();
      wr_sel      = 2'($urandom_range(0, 3));
      alu_result  = $urandom;
      mem_data    = $urandom;
      link_pc     = $urandom;
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_dst   = rnd_addr();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
